// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational off the flop table; updates, flush and reset land on the rising edge.
module branch_target_buffer #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              flush
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_MAX     = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_W'(1);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [CTR_W-1:0] ctr_cur;
    logic [CTR_W-1:0] ctr_d;
    logic             unused_pc_bits;

    // Instructions are word aligned, so the two low PC bits never select anything.
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[ADDR_W-1:IDX_W+2];

    always_comb begin
        pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit && ctr_q[lk_idx][CTR_W-1];
        pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + ADDR_W'(4);
    end

    assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign ctr_cur = ctr_q[up_idx];

    always_comb begin
        // NOTE: default first so every path through the block assigns ctr_d and no latch is inferred.
        ctr_d = ctr_cur;
        if (upd_taken) begin
            if (ctr_cur != CTR_MAX) ctr_d = ctr_cur + CTR_W'(1);
        end else begin
            if (ctr_cur != '0) ctr_d = ctr_cur - CTR_W'(1);
        end
    end

    // NOTE: the table is plain flops (not RAM) so reset and flush can clear every entry in a single edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WEAK_NT;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_d;
                if (upd_taken) target_q[up_idx] <= upd_target;
            end else if (upd_taken) begin
                // A taken miss evicts whatever occupies the slot.
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                ctr_q[up_idx]    <= CTR_WEAK_T;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench: two BTB configurations driven in lockstep against a line-addressed
// behavioural model, plus hand-computed directed expectations.
module tb_branch_target_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        flush;
    logic        upd_valid;
    logic        upd_taken;
    logic [31:0] lookup_pc;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;

    logic        a_hit, a_taken;
    logic [31:0] a_tgt;
    logic        b_hit, b_taken;
    logic [15:0] b_tgt;

    branch_target_buffer #(.ADDR_W(32), .ENTRIES(16), .CTR_W(2)) dut_a (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .pred_hit(a_hit), .pred_taken(a_taken), .pred_target(a_tgt),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .flush(flush)
    );

    branch_target_buffer #(.ADDR_W(16), .ENTRIES(4), .CTR_W(3)) dut_b (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc[15:0]),
        .pred_hit(b_hit), .pred_taken(b_taken), .pred_target(b_tgt),
        .upd_valid(upd_valid), .upd_pc(upd_pc[15:0]), .upd_taken(upd_taken),
        .upd_target(upd_target[15:0]), .flush(flush)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each slot remembers the full word-line address (pc>>2) of its branch.
    logic [31:0] m_mask [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};
    int          m_ent  [2] = '{16, 4};
    int          m_cmax [2] = '{3, 7};
    int          m_half [2] = '{2, 4};
    bit          m_valid [2][16];
    logic [31:0] m_line  [2][16];
    logic [31:0] m_tgt   [2][16];
    int          m_ctr   [2][16];
    bit          m_init = 1'b0;

    function automatic void model_lookup(input int d, input logic [31:0] pc_raw,
                                         output bit hit, output bit taken, output logic [31:0] tgt);
        logic [31:0] pc;
        logic [31:0] line;
        int          idx;
        pc    = pc_raw & m_mask[d];
        line  = pc >> 2;
        idx   = int'(line % m_ent[d]);
        hit   = m_valid[d][idx] && (m_line[d][idx] == line);
        taken = hit && (m_ctr[d][idx] >= m_half[d]);
        tgt   = taken ? m_tgt[d][idx] : ((pc + 32'd4) & m_mask[d]);
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_init = 1'b1;
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 16; i++) m_valid[d][i] = 1'b0;
        end else if (flush) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 16; i++) m_valid[d][i] = 1'b0;
        end else if (upd_valid) begin
            for (int d = 0; d < 2; d++) begin
                logic [31:0] line;
                int          idx;
                line = (upd_pc & m_mask[d]) >> 2;
                idx  = int'(line % m_ent[d]);
                if (m_valid[d][idx] && m_line[d][idx] == line) begin
                    if (upd_taken) begin
                        if (m_ctr[d][idx] < m_cmax[d]) m_ctr[d][idx]++;
                        m_tgt[d][idx] = upd_target & m_mask[d];
                    end else if (m_ctr[d][idx] > 0) begin
                        m_ctr[d][idx]--;
                    end
                end else if (upd_taken) begin
                    m_valid[d][idx] = 1'b1;
                    m_line[d][idx]  = line;
                    m_tgt[d][idx]   = upd_target & m_mask[d];
                    m_ctr[d][idx]   = m_half[d];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            bit          h, t;
            logic [31:0] g;
            model_lookup(0, lookup_pc, h, t, g);
            check("a_hit", a_hit, h);
            check("a_taken", a_taken, t);
            check("a_target", a_tgt, g);
            model_lookup(1, lookup_pc, h, t, g);
            check("b_hit", b_hit, h);
            check("b_taken", b_taken, t);
            check("b_target", {16'h0, b_tgt}, g);
        end
    end

    task automatic apply(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        lookup_pc  = pc;
        upd_pc     = pc;
        upd_taken  = t;
        upd_target = tgt;
        upd_valid  = 1'b1;
        flush      = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic look(input string name, input logic [31:0] pc, input bit b_side,
                        input logic eh, input logic et, input logic [31:0] etg);
        lookup_pc = pc;
        upd_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        if (!b_side) begin
            check({name, "_hit"}, a_hit, eh);
            check({name, "_taken"}, a_taken, et);
            check({name, "_target"}, a_tgt, etg);
        end else begin
            check({name, "_hit"}, b_hit, eh);
            check({name, "_taken"}, b_taken, et);
            check({name, "_target"}, {16'h0, b_tgt}, etg);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        upd_valid = 1'b0;
        flush     = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        if ($urandom_range(0, 15) == 0)
            pc = 32'hFFFF_FFC0 | 32'($urandom_range(0, 63));
        else
            pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 63)) << 2)
                 | 32'($urandom_range(0, 3));
        return pc;
    endfunction

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        upd_valid  = 1'b0;
        upd_taken  = 1'b0;
        upd_pc     = '0;
        upd_target = '0;
        lookup_pc  = 32'h24;

        // Outputs while reset is still held.
        @(posedge clk); #1;
        @(negedge clk);
        check("in_rst_hit", a_hit, 1'b0);
        check("in_rst_target", a_tgt, 32'h28);
        @(posedge clk); #1;
        reset = 1'b1;

        look("post_rst", 32'h24, 0, 1'b0, 1'b0, 32'h28);

        // Allocation is invisible in the cycle of the update edge itself.
        lookup_pc  = 32'h24;
        upd_pc     = 32'h24;
        upd_taken  = 1'b1;
        upd_target = 32'h10;
        upd_valid  = 1'b1;
        @(negedge clk);
        check("same_cycle_hit", a_hit, 1'b0);
        @(posedge clk); #1;
        upd_valid = 1'b0;
        look("alloc", 32'h24, 0, 1'b1, 1'b1, 32'h10);

        // Counter walk: 2 -> 1 -> 0 -> 0, then up to saturation at 3.
        apply(32'h24, 1'b0, 32'h0);
        look("nt1", 32'h24, 0, 1'b1, 1'b0, 32'h28);
        apply(32'h24, 1'b0, 32'h0);
        look("nt2", 32'h24, 0, 1'b1, 1'b0, 32'h28);
        apply(32'h24, 1'b0, 32'h0);
        look("nt3", 32'h24, 0, 1'b1, 1'b0, 32'h28);
        apply(32'h24, 1'b1, 32'h10);
        apply(32'h24, 1'b1, 32'h10);
        look("t2", 32'h24, 0, 1'b1, 1'b1, 32'h10);
        for (int k = 0; k < 4; k++) apply(32'h24, 1'b1, 32'h10);
        apply(32'h24, 1'b0, 32'h0);
        look("sat_nt1", 32'h24, 0, 1'b1, 1'b1, 32'h10);
        apply(32'h24, 1'b0, 32'h0);
        look("sat_nt2", 32'h24, 0, 1'b1, 1'b0, 32'h28);
        apply(32'h24, 1'b1, 32'h44);
        look("retarget", 32'h24, 0, 1'b1, 1'b1, 32'h44);

        // Aliasing at index 9 evicts the older branch.
        do_reset();
        apply(32'h24, 1'b1, 32'h10);
        apply(32'h64, 1'b1, 32'h80);
        look("evict_old", 32'h24, 0, 1'b0, 1'b0, 32'h28);
        look("evict_new", 32'h64, 0, 1'b1, 1'b1, 32'h80);
        apply(32'h24, 1'b0, 32'h99);
        look("nt_miss_keeps", 32'h64, 0, 1'b1, 1'b1, 32'h80);

        // Flush beats a simultaneous taken update.
        do_reset();
        for (int k = 0; k < 4; k++) apply(32'h100 + 32'(4 * k), 1'b1, 32'h200 + 32'(4 * k));
        look("pre_flush", 32'h108, 0, 1'b1, 1'b1, 32'h208);
        lookup_pc  = 32'h100;
        upd_pc     = 32'h30;
        upd_taken  = 1'b1;
        upd_target = 32'h77;
        upd_valid  = 1'b1;
        flush      = 1'b1;
        @(negedge clk);
        check("flush_cycle_hit", a_hit, 1'b1);
        @(posedge clk); #1;
        flush     = 1'b0;
        upd_valid = 1'b0;
        for (int k = 0; k < 4; k++)
            look("flushed", 32'h100 + 32'(4 * k), 0, 1'b0, 1'b0, 32'h104 + 32'(4 * k));
        look("flush_upd", 32'h30, 0, 1'b0, 1'b0, 32'h34);

        // One-cycle reset mid-operation beats a concurrent update.
        for (int k = 0; k < 4; k++) apply(32'h100 + 32'(4 * k), 1'b1, 32'h300 + 32'(4 * k));
        look("pre_rst", 32'h104, 0, 1'b1, 1'b1, 32'h304);
        upd_pc     = 32'h30;
        upd_taken  = 1'b1;
        upd_target = 32'h55;
        upd_valid  = 1'b1;
        reset      = 1'b0;
        @(posedge clk); #1;
        reset     = 1'b1;
        upd_valid = 1'b0;
        for (int k = 0; k < 4; k++)
            look("rst_empty", 32'h100 + 32'(4 * k), 0, 1'b0, 1'b0, 32'h104 + 32'(4 * k));
        look("rst_upd", 32'h30, 0, 1'b0, 1'b0, 32'h34);
        look("rst_b", 32'h104, 1, 1'b0, 1'b0, 32'h108);
        look("wrap_a", 32'hFFFF_FFFC, 0, 1'b0, 1'b0, 32'h0);
        look("wrap_b", 32'hFFFF_FFFC, 1, 1'b0, 1'b0, 32'h0);

        // Narrow configuration: allocate at 4, saturate at 7, four not-takens to drop below 4.
        do_reset();
        apply(32'h24, 1'b1, 32'h10);
        look("b_alloc", 32'h24, 1, 1'b1, 1'b1, 32'h10);
        for (int k = 0; k < 5; k++) apply(32'h24, 1'b1, 32'h10);
        for (int k = 0; k < 3; k++) apply(32'h24, 1'b0, 32'h0);
        look("b_sat", 32'h24, 1, 1'b1, 1'b1, 32'h10);
        apply(32'h24, 1'b0, 32'h0);
        look("b_nt", 32'h24, 1, 1'b1, 1'b0, 32'h28);

        // Random traffic; update-side inputs are X whenever the strobe is low.
        for (int n = 0; n < 3000; n++) begin
            lookup_pc = rand_pc();
            if ($urandom_range(0, 99) < 60) begin
                upd_valid  = 1'b1;
                upd_pc     = rand_pc();
                upd_taken  = ($urandom_range(0, 99) < 60);
                upd_target = $urandom;
            end else begin
                upd_valid  = 1'b0;
                upd_pc     = 'x;
                upd_taken  = 1'bx;
                upd_target = 'x;
            end
            flush = ($urandom_range(0, 99) < 2);
            reset = ($urandom_range(0, 199) != 0);
            @(posedge clk); #1;
        end

        reset     = 1'b1;
        flush     = 1'b0;
        upd_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, PC and target width in bits.
REQ-002 SHALL provide parameter ENTRIES, default 16, table depth; power of two, minimum 2; IDX_W = log2(ENTRIES).
REQ-003 SHALL provide parameter CTR_W, default 2, saturating predictor counter width; minimum 1.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port lookup_pc  input  ADDR_W  fetch-stage PC to predict.
REQ-007 SHALL have port pred_hit  output  1  valid entry with matching tag exists for lookup_pc.
REQ-008 SHALL have port pred_taken  output  1  predict taken.
REQ-009 SHALL have port pred_target  output  ADDR_W  predicted next PC.
REQ-010 SHALL have port upd_valid  input  1  resolved-branch update strobe from ID stage.
REQ-011 SHALL have port upd_pc  input  ADDR_W  PC of resolved branch.
REQ-012 SHALL have port upd_taken  input  1  actual branch outcome.
REQ-013 SHALL have port upd_target  input  ADDR_W  actual taken target.
REQ-014 SHALL have port flush  input  1  invalidate entire table.

Function
REQ-015 Entry SHALL hold: valid, tag = pc[ADDR_W-1:IDX_W+2], target[ADDR_W], ctr[CTR_W]; direct-mapped, index = pc[IDX_W+1:2]; pc[1:0] ignored.
REQ-016 Lookup SHALL be combinational from registered table state: zero-cycle latency, same cycle as lookup_pc.
REQ-017 pred_hit SHALL = valid & (tag == lookup_pc tag field) at index(lookup_pc).
REQ-018 pred_taken SHALL = pred_hit & ctr[CTR_W-1].
REQ-019 pred_target SHALL = stored target when pred_taken, else lookup_pc + 4 (modulo 2^ADDR_W, wraps at top of address space).
REQ-020 Update on upd_valid, hit at index(upd_pc): ctr +1 if upd_taken, saturating at 2^CTR_W-1; ctr -1 if not taken, saturating at 0; target <= upd_target only when upd_taken.
REQ-021 Update on upd_valid, miss, upd_taken=1: allocate/overwrite entry: valid=1, tag, target=upd_target, ctr=2^(CTR_W-1) (weakly taken); previous occupant evicted.
REQ-022 Update on upd_valid, miss, upd_taken=0: no table change.
REQ-023 Lookup and update same cycle, same index: lookup SHALL reflect pre-edge contents; no bypass.
REQ-024 flush=1 SHALL clear every valid bit at that edge; flush overrides a simultaneous upd_valid (update discarded); ctr/target/tag bits need not change.
REQ-025 Storage SHALL be flops, not inferred RAM, so full-table flush completes in one cycle.
REQ-026 Inputs when upd_valid=0 SHALL be don't-care; X on them SHALL NOT corrupt state.

Reset
REQ-027 reset=0 at a rising edge SHALL clear all valid bits, set every ctr to 2^(CTR_W-1)-1 (weakly not-taken), targets and tags to 0; reset overrides flush and upd_valid.
REQ-028 During and after reset, outputs SHALL read pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
REQ-029 Reset asserted mid-operation for one cycle SHALL fully empty a populated table; no partial state retained.

Verification
REQ-030 Post-reset, lookup_pc=0x24 -> pred_hit=0, pred_taken=0, pred_target=0x28.
REQ-031 upd_valid, upd_pc=0x24, upd_taken=1, upd_target=0x10; next cycle lookup 0x24 -> hit=1, taken=1, target=0x10; same-cycle lookup at the update edge -> hit=0.
REQ-032 Following REQ-031, three not-taken updates to 0x24 -> ctr 2,1,0,0; taken=0, target=0x28, hit=1; then two taken updates -> ctr 2, taken=1; four more taken updates saturate at 3.
REQ-033 ENTRIES=16: allocate 0x24 taken->0x10, then 0x64 taken->0x80 (same index 9) -> lookup 0x24 hit=0, lookup 0x64 hit=1 target=0x80; not-taken update to 0x24 leaves 0x64 entry intact.
REQ-034 Populate 4 entries, assert flush together with a taken update to 0x30 -> next cycle all four and 0x30 miss.
REQ-035 Populated table, reset=0 one cycle concurrent with upd_valid -> all lookups miss; lookup_pc=0xFFFFFFFC -> pred_target=0x00000000; repeat with ADDR_W=16, ENTRIES=4, CTR_W=3 (allocate ctr=4, saturate 7).
